// File: rtl/led_frame_writer.sv
// led_frame_writer: packs a raster stream of 24-bit RGB pixels into the
// shared 48-bit frame RAM (top-half pixel in [23:0], bottom-half pixel in
// [47:24]) by read-modify-write, and offers a bulk clear of the RAM.
// Optional build macro LED_DOUBLE_BUFFER_EN adds a bank bit as the ram_addr
// MSB plus a disp_bank output; the writer fills one bank while the display
// reads the other, and the banks swap at every frame_done.
module led_frame_writer #(
    parameter int          COL_BITS    = 6,
    parameter int          ROW_BITS    = 4,
    parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [23:0]                  pix_data,
    input  logic                         pix_sof,
    input  logic                         clear_req,
`ifdef LED_DOUBLE_BUFFER_EN
    output logic [COL_BITS+ROW_BITS:0]   ram_addr,
`else
    output logic [COL_BITS+ROW_BITS-1:0] ram_addr,
`endif
    output logic [47:0]                  ram_wdata,
    output logic                         ram_we,
    input  logic [47:0]                  ram_rdata,
    output logic                         busy,
    output logic                         frame_done,
`ifdef LED_DOUBLE_BUFFER_EN
    output logic                         disp_bank,
`endif
    output logic                         display_ena
);

    localparam int AW = COL_BITS + ROW_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR,
        S_CLR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [COL_BITS-1:0] x;
    logic [ROW_BITS:0]   y;
    logic [AW-1:0]       clr_cnt;
    logic                wr_bank;

    // Data path registers: no reset, they are always loaded before use.
    logic [23:0]         pix_p0;
    logic [COL_BITS-1:0] lx_p0;
    logic [ROW_BITS:0]   ly_p0;
    logic [47:0]         word_p1;

    logic                frame_end;
    logic [AW-1:0]       addr_lo;
    logic                addr_act;

    // Replace one half of a RAM word with the new pixel; the other half passes bit-exact.
    function automatic logic [47:0] merge_half(input logic [47:0] word,
                                               input logic [23:0] pix,
                                               input logic        half);
        merge_half = half ? {pix, word[23:0]} : {word[47:24], pix};
    endfunction

    assign frame_end = (lx_p0 == '1) && (ly_p0 == '1);

`ifdef LED_DOUBLE_BUFFER_EN
    // disp_bank is the stored bit so it resets to 0; the writer uses the other bank.
    logic disp_bank_q;
    assign disp_bank = disp_bank_q;
    assign wr_bank   = ~disp_bank_q;
`else
    assign wr_bank = 1'b0;
`endif

    // Control state: FSM, raster position, clear counter, frame flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            clr_cnt     <= '0;
            frame_done  <= 1'b0;
            display_ena <= 1'b0;
`ifdef LED_DOUBLE_BUFFER_EN
            disp_bank_q <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) clr_cnt <= '0;
                end
                S_WR: begin
                    x <= lx_p0 + 1'b1;
                    y <= (lx_p0 == '1) ? ly_p0 + 1'b1 : ly_p0;
                    if (frame_end) begin
                        frame_done  <= 1'b1;
                        display_ena <= 1'b1;
`ifdef LED_DOUBLE_BUFFER_EN
                        disp_bank_q <= ~disp_bank_q;
`endif
                    end
                end
                S_CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        x <= '0;
                        y <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0: latch pixel and target position on handshake; stage p1: merged word.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && pix_valid && pix_ready) begin
            pix_p0 <= pix_data;
            lx_p0  <= pix_sof ? '0 : x;
            ly_p0  <= pix_sof ? '0 : y;
        end
        if (state == S_MRG) begin
            word_p1 <= merge_half(ram_rdata, pix_p0, ly_p0[ROW_BITS]);
        end
    end

    // Next-state logic and RAM-side outputs; rst forces the write port quiet at once.
    always_comb begin
        state_nxt = state;
        addr_lo   = '0;
        addr_act  = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            S_IDLE: begin
                if (clear_req)      state_nxt = S_CLR;
                else if (pix_valid) state_nxt = S_RD;
            end
            S_RD: begin
                addr_lo   = {ly_p0[ROW_BITS-1:0], lx_p0};
                addr_act  = 1'b1;
                state_nxt = S_MRG;
            end
            S_MRG: begin
                addr_lo   = {ly_p0[ROW_BITS-1:0], lx_p0};
                addr_act  = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                addr_lo   = {ly_p0[ROW_BITS-1:0], lx_p0};
                addr_act  = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = word_p1;
                state_nxt = S_IDLE;
            end
            S_CLR: begin
                addr_lo   = clr_cnt;
                addr_act  = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = {CLEAR_COLOR, CLEAR_COLOR};
                if (clr_cnt == '1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) begin
            addr_act  = 1'b0;
            ram_we    = 1'b0;
            ram_wdata = '0;
        end
`ifdef LED_DOUBLE_BUFFER_EN
        ram_addr = addr_act ? {wr_bank, addr_lo} : '0;
`else
        ram_addr = addr_act ? addr_lo : '0;
`endif
    end

    assign pix_ready = (state == S_IDLE) && !clear_req && !rst;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_led_frame_writer.sv
// Bench for led_frame_writer (default single-bank build): behavioural RAM,
// reference frame memory and a scoreboard of expected RAM writes and
// frame_done pulses.
module tb_led_frame_writer;

    localparam int COL_BITS = 6;
    localparam int ROW_BITS = 4;
    localparam int AW       = COL_BITS + ROW_BITS;
    localparam int NWORDS   = 1 << AW;
    localparam logic [23:0] CLEAR_COLOR = 24'h000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [23:0]   pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          clear_req = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [47:0]   ram_wdata;
    logic          ram_we;
    logic [47:0]   ram_rdata = '0;
    logic          busy;
    logic          frame_done;
    logic          display_ena;

    led_frame_writer #(
        .COL_BITS(COL_BITS),
        .ROW_BITS(ROW_BITS),
        .CLEAR_COLOR(CLEAR_COLOR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .clear_req(clear_req),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we(ram_we),
        .ram_rdata(ram_rdata),
        .busy(busy),
        .frame_done(frame_done),
        .display_ena(display_ena)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous frame RAM seen by the DUT.
    logic [47:0] mem [NWORDS];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // mode 0: exact cycle, 1: one cycle after previous write, 2: any cycle
    typedef struct {
        logic [AW-1:0] addr;
        logic [47:0]   data;
        int            cyc;
        int            mode;
    } wr_t;

    wr_t exp_q[$];
    int  fd_q[$];
    int  fd_count = 0;
    int  last_wr  = 0;

    logic [47:0]         ref_mem [NWORDS];
    logic [COL_BITS-1:0] ref_x = '0;
    logic [ROW_BITS:0]   ref_y = '0;

    // Output monitor: every write and frame_done pulse must match the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(ram_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(ram_addr), 64'(e.addr));
                check("wr_data", 64'(ram_wdata), 64'(e.data));
                if (e.mode == 0) check("wr_latency", 64'(cyc), 64'(e.cyc));
                if (e.mode == 1) check("clr_consec", 64'(cyc), 64'(last_wr + 1));
                if (e.mode != 0) check("clr_busy", 64'(busy), 64'(1));
            end
            last_wr = cyc;
        end
        if (frame_done) begin
            fd_count++;
            if (fd_q.size() == 0) check("fd_unexpected", 64'(cyc), 64'hFFFF);
            else check("fd_cycle", 64'(cyc), 64'(fd_q.pop_front()));
            check("dena_at_fd", 64'(display_ena), 64'(1));
        end
    end

    task automatic send_pixel(input logic [23:0] d, input logic sof);
        int n;
        int hs;
        wr_t e;
        logic [AW-1:0] a;
        logic [47:0] w;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        #1;
        n = 0;
        while (!pix_ready && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!pix_ready) begin
            check("hs_timeout", 64'(0), 64'(1));
            pix_valid = 1'b0;
            return;
        end
        hs = cyc;
        if (sof) begin
            ref_x = '0;
            ref_y = '0;
        end
        a = {ref_y[ROW_BITS-1:0], ref_x};
        w = ref_mem[a];
        if (ref_y[ROW_BITS]) w[47:24] = d;
        else w[23:0] = d;
        ref_mem[a] = w;
        e.addr = a; e.data = w; e.cyc = hs + 3; e.mode = 0;
        exp_q.push_back(e);
        if (ref_x == '1 && ref_y == '1) fd_q.push_back(hs + 4);
        if (ref_x == '1) ref_y = ref_y + 1'b1;
        ref_x = ref_x + 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic expect_clear();
        wr_t e;
        for (int i = 0; i < NWORDS; i++) begin
            e.addr = AW'(i); e.data = {CLEAR_COLOR, CLEAR_COLOR};
            e.cyc = 0; e.mode = (i == 0) ? 2 : 1;
            exp_q.push_back(e);
            ref_mem[i] = {CLEAR_COLOR, CLEAR_COLOR};
        end
        ref_x = '0;
        ref_y = '0;
    endtask

    task automatic wait_q(input int lim);
        int n = 0;
        while (exp_q.size() > lim && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > lim) check("queue_timeout", 64'(exp_q.size()), 64'(lim));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] w5;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]     = {24'($urandom), 24'($urandom)};
            ref_mem[i] = mem[i];
        end
        mem[0]     = 48'hAABBCC_112233;
        ref_mem[0] = 48'hAABBCC_112233;

        // Reset held for 3 cycles while a pixel is offered.
        rst = 1'b1;
        pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(pix_ready), 64'(0));
        check("rst_we", 64'(ram_we), 64'(0));
        check("rst_addr", 64'(ram_addr), 64'(0));
        check("rst_wdata", 64'(ram_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_fd", 64'(frame_done), 64'(0));
        check("rst_dena", 64'(display_ena), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(pix_ready), 64'(1));
        pix_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a pixel: no write may follow.
        pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 24'h123456;
        @(negedge clk);
        pix_valid = 1'b0; pix_sof = 1'b0;
        check("abort_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_idle", 64'(busy), 64'(0));

        // Top-half read-modify-write at (0,0).
        send_pixel(24'h0000FF, 1'b1);
        wait_q(0);
        @(negedge clk);
        check("top_rmw_word", 64'(mem[0]), 64'(48'hAABBCC_0000FF));

        // Walk to (5,16) and write a bottom-half pixel.
        while (!(ref_x == 6'd5 && ref_y == 5'd16)) send_pixel(24'($urandom), 1'b0);
        wait_q(0);
        @(negedge clk);
        w5 = mem[5];
        send_pixel(24'h00FF00, 1'b0);
        wait_q(0);
        @(negedge clk);
        check("bot_rmw_hi", 64'(mem[5][47:24]), 64'(24'h00FF00));
        check("bot_rmw_lo", 64'(mem[5][23:0]), 64'(w5[23:0]));
        check("no_fd_yet", 64'(fd_count), 64'(0));

        // Two full frames back to back; sof restarts mid-frame without frame_done.
        for (int i = 0; i < 2048; i++) begin
            if (i == 2047) check("dena_before_frame", 64'(display_ena), 64'(0));
            send_pixel(24'($urandom), i == 0);
        end
        wait_q(0);
        repeat (3) @(negedge clk);
        check("frame1_fd_count", 64'(fd_count), 64'(1));
        check("frame1_dena", 64'(display_ena), 64'(1));
        for (int i = 0; i < 2048; i++) begin
            if (i == 1024) check("frame2_dena_mid", 64'(display_ena), 64'(1));
            send_pixel(24'($urandom), i == 0);
        end
        wait_q(0);
        repeat (3) @(negedge clk);
        check("frame2_fd_count", 64'(fd_count), 64'(2));

        // Clear requested while a pixel is in flight.
        send_pixel(24'hC0FFEE, 1'b0);
        clear_req = 1'b1;
        #1;
        check("clr_ready_low", 64'(pix_ready), 64'(0));
        expect_clear();
        wait_q(NWORDS - 1);
        clear_req = 1'b0;
        wait_q(0);
        @(negedge clk);
        check("clr_done_idle", 64'(busy), 64'(0));
        send_pixel(24'h5A5A5A, 1'b0);
        wait_q(0);
        @(negedge clk);
        check("post_clr_word0", 64'(mem[0]), 64'({CLEAR_COLOR, 24'h5A5A5A}));

        // Clear and pixel offered in the same idle cycle.
        pix_valid = 1'b1; pix_data = 24'h3C3C3C; pix_sof = 1'b0;
        clear_req = 1'b1;
        #1;
        check("coll_ready", 64'(pix_ready), 64'(0));
        expect_clear();
        wait_q(NWORDS - 1);
        clear_req = 1'b0;
        send_pixel(24'h3C3C3C, 1'b0);
        wait_q(0);
        repeat (3) @(negedge clk);
        check("coll_word0", 64'(mem[0]), 64'({CLEAR_COLOR, 24'h3C3C3C}));
        check("clr_keeps_dena", 64'(display_ena), 64'(1));
        check("final_fd_count", 64'(fd_count), 64'(2));
        check("fd_q_empty", 64'(fd_q.size()), 64'(0));
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
